// File: rtl/motor_pkg.sv
// Shared encodings for the motor command scheduler: speed codes, direction
// classes, scheduler states and the direction helpers.
package motor_pkg;

    typedef enum logic [1:0] {
        MOTOR_STOP   = 2'b00,
        MOTOR_FOR    = 2'b01,
        MOTOR_BACK   = 2'b10,
        FAST_FORWARD = 2'b11
    } speed_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_FWD  = 2'b01,
        DIR_REV  = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DEAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    function automatic dir_t dir_of(input speed_t s);
        case (s)
            MOTOR_FOR, FAST_FORWARD: return DIR_FWD;
            MOTOR_BACK:              return DIR_REV;
            default:                 return DIR_NONE;
        endcase
    endfunction

    function automatic logic reverses(input dir_t new_dir, input dir_t old_dir);
        return ((new_dir == DIR_FWD) && (old_dir == DIR_REV)) ||
               ((new_dir == DIR_REV) && (old_dir == DIR_FWD));
    endfunction

endpackage

// File: rtl/motor_sched_if.sv
// Request/acknowledge and motor-drive signals between the two requesters,
// the scheduler and the PWM block.
interface motor_sched_if #(
    parameter int DUR_W = 16
);
    logic             lo_req;
    logic [1:0]       lo_cmd;
    logic [DUR_W-1:0] lo_dur;
    logic             lo_ack;
    logic             hi_req;
    logic [1:0]       hi_cmd;
    logic [DUR_W-1:0] hi_dur;
    logic             hi_ack;
    logic             abort;
    logic             done;
    logic             busy;
    logic             owner;
    logic [1:0]       speed;

    modport master (
        output lo_req, lo_cmd, lo_dur, hi_req, hi_cmd, hi_dur,
        input  lo_ack, hi_ack, abort, done, busy, owner, speed
    );

    modport slave (
        input  lo_req, lo_cmd, lo_dur, hi_req, hi_cmd, hi_dur,
        output lo_ack, hi_ack, abort, done, busy, owner, speed
    );
endinterface

// File: rtl/motor_sched_ms_timer.sv
// Millisecond timer: prescaler plus ms counter, loaded by start, giving a
// single-cycle expire pulse in the last cycle of the programmed interval.
module ms_timer #(
    parameter int TICKS_PER_MS = 1000,
    parameter int DUR_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DUR_W-1:0] target,
    output logic             expire
);
    localparam int               PRE_W   = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_MS - 1);

    logic [PRE_W-1:0] pre;
    logic [DUR_W-1:0] ms_cnt;
    logic [DUR_W-1:0] tgt;
    logic             active;

    // Stops itself after expiring, so the ms counter can never wrap.
    assign expire = active && (pre == PRE_MAX) && (ms_cnt == tgt - DUR_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre    <= '0;
            ms_cnt <= '0;
            tgt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            pre    <= '0;
            ms_cnt <= '0;
            tgt    <= target;
            active <= 1'b1;
        end else if (active) begin
            if (pre == PRE_MAX) begin
                pre <= '0;
                if (expire) begin
                    active <= 1'b0;
                end else begin
                    ms_cnt <= ms_cnt + DUR_W'(1);
                end
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end
endmodule

// File: rtl/motor_sched.sv
// Two-requester motor command scheduler with high-priority preemption and
// a forced STOP dead time before any direction reversal.
module motor_sched
    import motor_pkg::*;
#(
    parameter int TICKS_PER_MS = 1000,
    parameter int DUR_W        = 16,
    parameter int DEAD_MS      = 20
) (
    input  logic         clkus,
    input  logic         rst_n,
    motor_sched_if.slave bus
);
    localparam logic [DUR_W-1:0] DEAD_DUR = DUR_W'(DEAD_MS);

    state_t           state, state_n;
    dir_t             last_dir, dir_n, eff_dir;
    speed_t           cmd_q, cmd_n, sel_cmd, speed;
    logic [DUR_W-1:0] dur_q, dur_n, sel_dur, phase_tgt;
    logic             owner, owner_n;
    logic             lo_ack, lo_ack_n, hi_ack, hi_ack_n;
    logic             abort, abort_n, done, done_n;
    logic             take_hi, take_lo, phase_start, phase_exp, quiet_exp;

    assign speed      = (state == ST_RUN) ? cmd_q : MOTOR_STOP;
    assign bus.speed  = speed;
    assign bus.busy   = (state != ST_IDLE);
    assign bus.owner  = owner;
    assign bus.lo_ack = lo_ack;
    assign bus.hi_ack = hi_ack;
    assign bus.abort  = abort;
    assign bus.done   = done;

    ms_timer #(.TICKS_PER_MS(TICKS_PER_MS), .DUR_W(DUR_W)) u_phase (
        .clk(clkus), .rst_n(rst_n), .start(phase_start), .target(phase_tgt), .expire(phase_exp)
    );

    // Held in load while moving, so it expires after DEAD_MS of continuous STOP.
    ms_timer #(.TICKS_PER_MS(TICKS_PER_MS), .DUR_W(DUR_W)) u_quiet (
        .clk(clkus), .rst_n(rst_n), .start(speed != MOTOR_STOP), .target(DEAD_DUR), .expire(quiet_exp)
    );

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        cmd_n       = cmd_q;
        dur_n       = dur_q;
        eff_dir     = (quiet_exp && (speed == MOTOR_STOP)) ? DIR_NONE : last_dir;
        dir_n       = eff_dir;
        lo_ack_n    = 1'b0;
        hi_ack_n    = 1'b0;
        abort_n     = 1'b0;
        done_n      = 1'b0;
        phase_start = 1'b0;
        phase_tgt   = dur_q;
        // A request in its own ack cycle is ignored; a completing run is not preempted.
        take_hi = bus.hi_req && !hi_ack &&
                  ((state == ST_IDLE) || (!owner && !((state == ST_RUN) && phase_exp)));
        take_lo = bus.lo_req && !lo_ack && (state == ST_IDLE) && !take_hi;
        sel_cmd = take_hi ? speed_t'(bus.hi_cmd) : speed_t'(bus.lo_cmd);
        sel_dur = take_hi ? bus.hi_dur : bus.lo_dur;

        if (take_hi || take_lo) begin
            cmd_n    = sel_cmd;
            dur_n    = sel_dur;
            owner_n  = take_hi;
            hi_ack_n = take_hi;
            lo_ack_n = take_lo;
            abort_n  = (state != ST_IDLE);
            if (sel_dur == '0) begin
                state_n = ST_IDLE;
                owner_n = 1'b0;
                done_n  = 1'b1;
            end else if (reverses(dir_of(sel_cmd), eff_dir)) begin
                state_n     = ST_DEAD;
                phase_start = 1'b1;
                phase_tgt   = DEAD_DUR;
            end else begin
                state_n     = ST_RUN;
                phase_start = 1'b1;
                phase_tgt   = sel_dur;
                if (dir_of(sel_cmd) != DIR_NONE) dir_n = dir_of(sel_cmd);
            end
        end else if (phase_exp) begin
            case (state)
                ST_DEAD: begin
                    state_n     = ST_RUN;
                    phase_start = 1'b1;
                    phase_tgt   = dur_q;
                    if (dir_of(cmd_q) != DIR_NONE) dir_n = dir_of(cmd_q);
                end
                ST_RUN: begin
                    state_n = ST_IDLE;
                    owner_n = 1'b0;
                    done_n  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkus) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            owner    <= 1'b0;
            last_dir <= DIR_NONE;
            lo_ack   <= 1'b0;
            hi_ack   <= 1'b0;
            abort    <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            last_dir <= dir_n;
            lo_ack   <= lo_ack_n;
            hi_ack   <= hi_ack_n;
            abort    <= abort_n;
            done     <= done_n;
        end
    end

    // Latched command and duration are only observed once state leaves IDLE.
    always_ff @(posedge clkus) begin
        cmd_q <= cmd_n;
        dur_q <= dur_n;
    end
endmodule

// File: tb/tb_motor_sched.sv
// Directed bench for motor_sched with 10 ticks per ms and a 2 ms dead time.
module tb_motor_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   n;
    int   d0;

    always #5 clk = ~clk;

    motor_sched_if #(.DUR_W(16)) bus ();

    motor_sched #(.TICKS_PER_MS(10), .DUR_W(16), .DEAD_MS(2)) dut (
        .clkus(clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles that speed holds value v, starting in the current cycle.
    task automatic measure(input logic [1:0] v, output int cnt);
        cnt = 0;
        while ((bus.speed === v) && (cnt < 300)) begin
            cnt++;
            step();
        end
    endtask

    task automatic set_lo(input logic req, input logic [1:0] cmd, input logic [15:0] dur);
        bus.lo_req = req;
        bus.lo_cmd = cmd;
        bus.lo_dur = dur;
    endtask

    task automatic set_hi(input logic req, input logic [1:0] cmd, input logic [15:0] dur);
        bus.hi_req = req;
        bus.hi_cmd = cmd;
        bus.hi_dur = dur;
    endtask

    initial begin
        rst_n = 1'b0;
        set_lo(1'b0, 2'b00, 16'd0);
        set_hi(1'b0, 2'b00, 16'd0);
        repeat (3) step();
        chk("rst_speed", 32'(bus.speed), 32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_pulses", 32'({bus.lo_ack, bus.hi_ack, bus.abort, bus.done}), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic low-priority run
        set_lo(1'b1, 2'b01, 16'd3);
        step();
        chk("t1_lo_ack", 32'(bus.lo_ack), 32'd1);
        chk("t1_busy",   32'(bus.busy),   32'd1);
        set_lo(1'b0, 2'b00, 16'd0);
        measure(2'b01, n);
        chk("t1_run_len", 32'(n), 32'd30);
        chk("t1_done",   32'(bus.done),  32'd1);
        chk("t1_idle",   32'(bus.busy),  32'd0);
        step();
        chk("t1_done_1cyc", 32'(bus.done), 32'd0);
        repeat (25) step();

        // Simultaneous requests: hi wins, lo then needs dead time
        set_lo(1'b1, 2'b01, 16'd5);
        set_hi(1'b1, 2'b10, 16'd2);
        step();
        chk("t2_acks",  32'({bus.hi_ack, bus.lo_ack}), 32'b10);
        chk("t2_owner", 32'(bus.owner), 32'd1);
        set_hi(1'b0, 2'b00, 16'd0);
        measure(2'b10, n);
        chk("t2_hi_len",  32'(n), 32'd20);
        chk("t2_hi_done", 32'({bus.done, bus.lo_ack}), 32'b10);
        step();
        chk("t2_lo_ack",  32'(bus.lo_ack), 32'd1);
        chk("t2_dead",    32'({bus.busy, bus.owner}), 32'b10);
        set_lo(1'b0, 2'b00, 16'd0);
        measure(2'b00, n);
        chk("t2_dead_len", 32'(n), 32'd20);
        measure(2'b01, n);
        chk("t2_lo_len",  32'(n), 32'd50);
        chk("t2_lo_done", 32'(bus.done), 32'd1);

        // Preemption of a running low-priority command
        set_lo(1'b1, 2'b01, 16'd5);
        step();
        d0 = done_cnt;
        chk("t3_lo_run", 32'({bus.lo_ack, bus.speed}), 32'b101);
        set_lo(1'b0, 2'b00, 16'd0);
        repeat (14) step();
        set_hi(1'b1, 2'b11, 16'd1);
        step();
        chk("t3_abort_ack", 32'({bus.abort, bus.hi_ack}), 32'b11);
        chk("t3_speed",     32'(bus.speed), 32'd3);
        chk("t3_owner",     32'(bus.owner), 32'd1);
        set_hi(1'b0, 2'b00, 16'd0);
        measure(2'b11, n);
        chk("t3_hi_len", 32'(n), 32'd10);
        step();
        chk("t3_done_count", 32'(done_cnt - d0), 32'd1);

        // Reversal after the motor has settled needs no dead time
        set_lo(1'b1, 2'b01, 16'd1);
        step();
        set_lo(1'b0, 2'b00, 16'd0);
        measure(2'b01, n);
        chk("t4_fwd_len", 32'(n), 32'd10);
        repeat (25) step();
        set_lo(1'b1, 2'b10, 16'd1);
        step();
        chk("t4_rev_now", 32'({bus.lo_ack, bus.speed}), 32'b110);
        set_lo(1'b0, 2'b00, 16'd0);
        measure(2'b10, n);
        chk("t4_rev_len", 32'(n), 32'd10);
        chk("t4_done",    32'(bus.done), 32'd1);

        // Zero duration
        set_hi(1'b1, 2'b01, 16'd0);
        step();
        chk("t5_ack_done", 32'({bus.hi_ack, bus.done}), 32'b11);
        chk("t5_quiet",    32'({bus.speed, bus.busy, bus.owner}), 32'd0);
        set_hi(1'b0, 2'b00, 16'd0);
        step();
        chk("t5_pulses_end", 32'({bus.hi_ack, bus.done}), 32'd0);

        // Reset during dead time clears direction memory
        set_hi(1'b1, 2'b01, 16'd2);
        step();
        chk("t6_dead", 32'({bus.hi_ack, bus.owner, bus.busy, bus.speed}), 32'b11100);
        set_hi(1'b0, 2'b00, 16'd0);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        chk("t6_rst_state", 32'({bus.speed, bus.owner, bus.busy}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_no_stale", 32'({bus.lo_ack, bus.hi_ack, bus.done, bus.busy}), 32'd0);
        end
        set_lo(1'b1, 2'b01, 16'd1);
        step();
        chk("t6_no_dead", 32'({bus.lo_ack, bus.speed}), 32'b101);
        set_lo(1'b0, 2'b00, 16'd0);
        measure(2'b01, n);
        chk("t6_run_len", 32'(n), 32'd10);
        chk("t6_done",    32'(bus.done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/motor_sched.md
Name: motor_sched

Overview:
- Command scheduler that owns the 2-bit speed input of the motor PWM block and shares it between two requesters.
- Low priority: line tracker. High priority: obstacle/safety logic.
- Each accepted command runs for a programmed number of milliseconds, then the motor returns to STOP.
- A high-priority request preempts a running low-priority command.
- A forced STOP dead time is inserted before any direction reversal.

Parameters:
- TICKS_PER_MS, 1000: clkus cycles per millisecond (clkus = 1 MHz).
- DUR_W, 16: width of duration fields, in ms.
- DEAD_MS, 20: STOP interval enforced before a direction reversal; must be ≥1.

Ports:
- clkus  in  1  1 MHz system clock
- rst_n  in  1  synchronous reset, active-low
- lo_req  in  1  low-priority request; held until lo_ack
- lo_cmd  in  2  speed code (00 STOP, 01 FOR, 10 BACK, 11 FAST_FORWARD)
- lo_dur  in  DUR_W  duration in ms
- lo_ack  out  1  one-cycle accept pulse
- hi_req, hi_cmd, hi_dur, hi_ack: same as the lo_* ports, for the high-priority requester
- abort  out  1  one-cycle pulse: running low-priority command was preempted
- done  out  1  one-cycle pulse: command completed its full duration
- busy  out  1  high in DEAD or RUN
- owner  out  1  requester of the current command (1 = hi); 0 when idle
- speed  out  2  drive code to the motor PWM block

Behaviour:
- Reset: on any clkus edge with rst_n=0, including mid-command:
  - state IDLE.
  - speed=00, busy=0, owner=0.
  - lo_ack, hi_ack, abort and done all 0.
  - last_dir=NONE; all counters 0.
- States: IDLE, DEAD, RUN.
- Acceptance:
  - Evaluated at each edge.
  - In IDLE: hi_req wins over lo_req.
  - In DEAD/RUN with owner=0: hi_req accepted (preemption).
  - With owner=1: no request accepted; a new hi_req waits.
  - Losing or blocked requests stay pending; requesters hold req/cmd/dur stable until ack.
- Ack timing:
  - On acceptance, cmd and dur are latched and the matching ack is high for exactly the next cycle.
  - The req input of the acked requester is ignored during its ack cycle, so there is no double accept.
- Preemption: abort pulses in the same cycle as hi_ack; the low-priority command is dropped and done does not pulse for it.
- Direction classes:
  - FOR and FAST_FORWARD are FWD; BACK is REV; STOP has no direction.
  - last_dir holds the class of the last moving command.
  - last_dir is cleared to NONE once speed has been continuously 00 for DEAD_MS ms (in IDLE or during a STOP command).
- Entry after acceptance:
  - If the new class is the opposite of last_dir, enter DEAD: speed=00 for exactly DEAD_MS×TICKS_PER_MS cycles, then RUN.
  - Otherwise enter RUN directly.
  - speed changes on the same edge at which ack rises.
- RUN:
  - speed = latched cmd for exactly dur×TICKS_PER_MS cycles.
  - Then speed=00 and done pulses for 1 cycle; return to IDLE with owner=0.
  - The DEAD time is not counted in dur.
- dur=0: accepted and acked; no DEAD or RUN; speed stays 00; done pulses in the ack cycle.
- STOP command with dur>0: speed=00 for dur ms; counts toward clearing last_dir.
- Back-to-back commands: a request pending at completion is evaluated in IDLE on the next edge, so speed=00 for at least 1 cycle between commands.
- Counters:
  - Prescaler wraps at TICKS_PER_MS-1.
  - ms counter is DUR_W bits, compared for equality against the latched duration minus 1 at prescaler wrap.
  - No counter overflow is possible; the maximum duration is 2^DUR_W-1 ms.
- busy=1 exactly when state is DEAD or RUN.

Decomposition:
- Package motor_pkg:
  - speed codes MOTOR_STOP, MOTOR_FOR, MOTOR_BACK, FAST_FORWARD.
  - direction class encoding NONE/FWD/REV.
  - scheduler state encoding.
- Sub-module ms_timer:
  - Prescaler plus ms counter.
  - Inputs: start (load and clear), target.
  - Output: expire, a 1-cycle pulse.
  - Used for DEAD, RUN and last_dir-clear timing.

Test Plan (simulation with TICKS_PER_MS=10, DEAD_MS=2):
- Reset and basic run: rst_n low for 3 cycles -> all outputs 0. Then lo_req cmd=01 dur=3 -> lo_ack 1 cycle, speed=01 for 30 cycles, then done pulse, speed=00, busy=0.
- Simultaneous requests: lo_req(01,5) and hi_req(10,2) asserted on the same edge -> hi_ack only, owner=1, speed=10 for 20 cycles. Then lo is accepted and enters DEAD for 20 cycles (speed=00) before speed=01 for 50 cycles.
- Preemption: hi_req(11,1) raised 15 cycles into lo run (01,5) -> abort and hi_ack in the same cycle, no DEAD (same class), speed=11 for 10 cycles, one done pulse total.
- Reversal after settle: lo(01,1) completes, then wait 25 idle cycles, then lo(10,1) -> no DEAD, speed=10 on the ack edge.
- Zero duration: hi(01,0) -> hi_ack and done in the same cycle, speed stays 00, busy stays 0.
- Reset mid-DEAD: rst_n low during DEAD -> next edge speed=00, owner=0, busy=0. After release, no stale ack/done, and last_dir=NONE: the opposite-direction command runs without DEAD.
